// File: rtl/comp_offset_cal.sv
// comp_offset_cal: SAR offset calibration for a clocked comparator.
// Each trial bit is majority-voted over 2**AVG_LOG2 samples; the final code is held until the next run.
module comp_offset_cal #(
  parameter int DAC_BITS      = 6,
  parameter int AVG_LOG2      = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_out,
  output logic                cal_mode,
  output logic [DAC_BITS-1:0] dac_code,
  output logic                busy,
  output logic                done,
  output logic                cal_valid,
  output logic                sat
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int CW = $clog2(N + SETTLE_CYCLES) + 1;
  localparam int IW = DAC_BITS > 1 ? $clog2(DAC_BITS) : 1;
  localparam logic [AVG_LOG2:0] HALF = (AVG_LOG2 + 1)'(N / 2);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  logic [2:0]          state_q, state_d;
  logic [DAC_BITS-1:0] code_q, code_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AVG_LOG2:0]   ones_q, ones_d;
  logic                busy_q, busy_d, done_q, done_d, valid_q, valid_d, sat_q, sat_d;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    done_d  = state_q == DONE;
    case (state_q)
      IDLE: if (start) begin
        code_d                = '0;
        code_d[DAC_BITS-1]    = 1'b1;
        idx_d                 = IW'(DAC_BITS - 1);
        cnt_d                 = '0;
        busy_d                = 1'b1;
        state_d               = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        cnt_d  = cnt_q + 1'b1;
        ones_d = ones_q + {{AVG_LOG2{1'b0}}, comp_out};
        if (cnt_q == CW'(N - 1)) state_d = DECIDE;
      end
      DECIDE: begin
        cnt_d = '0;
        // a tie is not a majority, so it clears the trial bit
        if (ones_q <= HALF) code_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          code_d[idx_q - 1'b1] = 1'b1;
          idx_d                = idx_q - 1'b1;
          state_d              = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        sat_d   = (code_q == '0) || (&code_q);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      code_q  <= DAC_BITS'(1) << (DAC_BITS - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end
  assign cal_mode  = busy_q;
  assign busy      = busy_q;
  assign dac_code  = code_q;
  assign done      = done_q;
  assign cal_valid = valid_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_comp_offset_cal.sv
// tb_comp_offset_cal: randomized checks of the offset calibrator against an ideal SAR reference.
module tb_comp_offset_cal;
  localparam int LAT = 223;
  localparam int BIT_CYC = 37;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, comp_out = 1'b0;
  logic cal_mode, busy, done, cal_valid, sat;
  logic [5:0] dac_code;
  int vectors = 0, miscompares = 0;
  int mode = 2, thr = 0;
  int exp_trial[0:5];
  int exp_final;
  logic [5:0] code_s[0:479];
  logic done_s[0:479], busy_s[0:479], cmode_s[0:479], valid_s[0:479], sat_s[0:479];
  int first_done, ndone;

  comp_offset_cal dut (
    .clk(clk), .rst(rst), .start(start), .comp_out(comp_out), .cal_mode(cal_mode),
    .dac_code(dac_code), .busy(busy), .done(done), .cal_valid(cal_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  // comparator behaviour: registered decision, threshold-based with optional noise
  always @(posedge clk)
    case (mode)
      0: comp_out <= (int'(dac_code) <= thr);
      1: comp_out <= 1'b1;
      3: comp_out <= ~comp_out;
      4: comp_out <= (int'(dac_code) <= thr) ^ ($urandom_range(31) < 3);
      default: comp_out <= 1'b0;
    endcase

  function automatic bit ideal_dec(input int m, input int t, input int code);
    return (m == 0 || m == 4) ? (code <= t) : (m == 1);
  endfunction

  task automatic build_ref(input int m, input int t);
    int res = 0;
    for (int b = 5; b >= 0; b--) begin
      exp_trial[5 - b] = res | (1 << b);
      if (ideal_dec(m, t, res | (1 << b))) res = res | (1 << b);
    end
    exp_final = res;
  endtask

  task automatic run_cal(input int m, input int t, input int t2, input bit hold, input bit pulses, input int len);
    mode = m;
    thr = t;
    first_done = -1;
    ndone = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      code_s[n] = dac_code; done_s[n] = done; busy_s[n] = busy;
      cmode_s[n] = cal_mode; valid_s[n] = cal_valid; sat_s[n] = sat;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      if (n == 223) thr = t2;
      if (!hold) start = pulses && (n % 50 == 10 || n == 221 || n == 222);
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    vectors++; if (dac_code !== 6'd32) begin miscompares++; $display("FAIL reset_code got %0d want 32", dac_code); end
    vectors++; if ({cal_mode, busy, done, cal_valid, sat} !== 5'b0) begin miscompares++;
      $display("FAIL reset_flags got %b want 00000", {cal_mode, busy, done, cal_valid, sat}); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_threshold(input int t);
    build_ref(0, t);
    run_cal(0, t, t, 0, 0, 240);
    vectors++; if (first_done != LAT) begin miscompares++; $display("FAIL thr%0d_latency got %0d want %0d", t, first_done, LAT); end
    vectors++; if (ndone != 1) begin miscompares++; $display("FAIL thr%0d_done_count got %0d want 1", t, ndone); end
    vectors++; if (code_s[LAT] !== 6'(exp_final)) begin miscompares++; $display("FAIL thr%0d_code got %0d want %0d", t, code_s[LAT], exp_final); end
    vectors++; if (sat_s[LAT] !== (exp_final == 0 || exp_final == 63)) begin miscompares++; $display("FAIL thr%0d_sat got %b", t, sat_s[LAT]); end
    vectors++; if (valid_s[LAT] !== 1'b1) begin miscompares++; $display("FAIL thr%0d_valid got %b want 1", t, valid_s[LAT]); end
    vectors++; if ({busy_s[0], cmode_s[0], busy_s[LAT-1], cmode_s[LAT-1], busy_s[LAT], cmode_s[LAT]} !== 6'b111100) begin
      miscompares++; $display("FAIL thr%0d_busy got %b want 111100", t,
        {busy_s[0], cmode_s[0], busy_s[LAT-1], cmode_s[LAT-1], busy_s[LAT], cmode_s[LAT]}); end
    for (int n = 0; n < 6 * BIT_CYC; n++) begin
      vectors++; if (code_s[n] !== 6'(exp_trial[n / BIT_CYC])) begin miscompares++;
        $display("FAIL thr%0d_trial cyc %0d got %0d want %0d", t, n, code_s[n], exp_trial[n / BIT_CYC]); end
    end
  endtask

  task automatic test_saturation;
    for (int m = 1; m <= 2; m++) begin
      build_ref(m, 0);
      run_cal(m, 0, 0, 0, 0, 230);
      vectors++; if (code_s[LAT] !== 6'(exp_final)) begin miscompares++; $display("FAIL sat_m%0d_code got %0d want %0d", m, code_s[LAT], exp_final); end
      vectors++; if (sat_s[LAT] !== 1'b1 || done_s[LAT] !== 1'b1) begin miscompares++;
        $display("FAIL sat_m%0d_flag got sat=%b done=%b want 1 1", m, sat_s[LAT], done_s[LAT]); end
    end
  endtask

  task automatic test_toggle;
    build_ref(3, 0);
    run_cal(3, 0, 0, 0, 0, 230);
    for (int k = 0; k < 6; k++) begin
      vectors++; if (code_s[k * BIT_CYC + 20] !== 6'(exp_trial[k])) begin miscompares++;
        $display("FAIL toggle_trial bit %0d got %0d want %0d", k, code_s[k * BIT_CYC + 20], exp_trial[k]); end
    end
    vectors++; if (code_s[LAT] !== 6'd0 || sat_s[LAT] !== 1'b1) begin miscompares++;
      $display("FAIL toggle_final got code=%0d sat=%b want 0 1", code_s[LAT], sat_s[LAT]); end
  endtask

  task automatic test_reset_mid;
    int t = $urandom_range(1, 62);
    int seen = 0;
    mode = 0;
    thr = t;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    vectors++; if (dac_code !== 6'd32 || busy !== 1'b0 || cal_mode !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset got code=%0d busy=%b cal_mode=%b want 32 0 0", dac_code, busy, cal_mode); end
    vectors++; if (done !== 1'b0 || cal_valid !== 1'b0 || sat !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset_flags got done=%b valid=%b sat=%b want 0 0 0", done, cal_valid, sat); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL mid_no_done got %0d active cycles want 0", seen); end
    build_ref(0, t);
    run_cal(0, t, t, 0, 0, 230);
    vectors++; if (first_done != LAT || code_s[LAT] !== 6'(exp_final)) begin miscompares++;
      $display("FAIL mid_recal got done@%0d code=%0d want %0d %0d", first_done, code_s[LAT], LAT, exp_final); end
  endtask

  task automatic test_start_during_busy;
    int t = $urandom_range(1, 62);
    build_ref(0, t);
    run_cal(0, t, t, 0, 1, 240);
    vectors++; if (ndone != 1 || first_done != LAT) begin miscompares++;
      $display("FAIL busy_start got %0d dones first@%0d want 1 @%0d", ndone, first_done, LAT); end
    vectors++; if (code_s[LAT] !== 6'(exp_final)) begin miscompares++;
      $display("FAIL busy_start_code got %0d want %0d", code_s[LAT], exp_final); end
    vectors++; if (busy_s[230] !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle got busy=%b want 0", busy_s[230]); end
  endtask

  task automatic test_noisy;
    build_ref(4, 20);
    run_cal(4, 20, 20, 0, 0, 230);
    vectors++; if (code_s[LAT] !== 6'd20) begin miscompares++; $display("FAIL noisy_code got %0d want 20", code_s[LAT]); end
    for (int n = 0; n < 6 * BIT_CYC; n++) begin
      vectors++; if (code_s[n] !== 6'(exp_trial[n / BIT_CYC])) begin miscompares++;
        $display("FAIL noisy_stable cyc %0d got %0d want %0d", n, code_s[n], exp_trial[n / BIT_CYC]); end
    end
  endtask

  task automatic test_back_to_back;
    int t2 = $urandom_range(1, 62);
    run_cal(0, 63, t2, 1, 0, 470);
    build_ref(0, t2);
    vectors++; if (first_done != LAT || code_s[LAT] !== 6'd63 || sat_s[LAT] !== 1'b1) begin miscompares++;
      $display("FAIL b2b_first got done@%0d code=%0d sat=%b want %0d 63 1", first_done, code_s[LAT], sat_s[LAT], LAT); end
    vectors++; if (busy_s[LAT] !== 1'b0 || busy_s[LAT+1] !== 1'b1) begin miscompares++;
      $display("FAIL b2b_restart got busy %b%b want 01", busy_s[LAT], busy_s[LAT+1]); end
    vectors++; if (sat_s[300] !== 1'b1 || valid_s[300] !== 1'b1) begin miscompares++;
      $display("FAIL b2b_hold got sat=%b valid=%b want 1 1", sat_s[300], valid_s[300]); end
    vectors++; if (done_s[2*LAT+1] !== 1'b1 || ndone != 2) begin miscompares++;
      $display("FAIL b2b_second_done got done=%b count=%0d want 1 2", done_s[2*LAT+1], ndone); end
    vectors++; if (code_s[2*LAT+1] !== 6'(exp_final) || sat_s[2*LAT+1] !== 1'b0) begin miscompares++;
      $display("FAIL b2b_second got code=%0d sat=%b want %0d 0", code_s[2*LAT+1], sat_s[2*LAT+1], exp_final); end
  endtask

  initial begin
    test_reset;
    test_threshold(37);
    repeat (2) test_threshold($urandom_range(1, 62));
    test_saturation;
    test_toggle;
    test_reset_mid;
    test_start_during_busy;
    test_noisy;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
